// File: rtl/mem_port_arbiter_pkg.sv
// ============================================================================
// Module   : mem_arb_pkg
// Purpose  : Shared types, constants and the access-legality check for the
//            memory port arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_arb_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    WAIT  = 3'd2,
    RESP  = 3'd3,
    ERR   = 3'd4
  } arb_state_t;

  typedef enum logic {
    GRANT_FETCH = 1'b0,
    GRANT_DATA  = 1'b1
  } grant_t;

  localparam int unsigned WORD_BYTES = 4;

  // Word-aligned and the whole word lies inside the array.
  function automatic logic addr_ok(input logic [31:0] addr, input int unsigned mem_bytes);
    return (addr[1:0] == 2'b00) && (addr <= 32'(mem_bytes - WORD_BYTES));
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_port_arbiter_if.sv
// ============================================================================
// Module   : mem_arb_if
// Purpose  : Fetch, load/store and memory-side signals of the port arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mem_arb_if;

  logic        i_req;
  logic [31:0] i_addr;
  logic        i_ack;
  logic [31:0] i_rdata;
  logic        i_err;

  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [3:0]  d_wstrb;
  logic        d_ack;
  logic [31:0] d_rdata;
  logic        d_err;

  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata;

  // Arbiter side.
  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, d_wstrb, mem_rdata,
    output i_ack, i_rdata, i_err, d_ack, d_rdata, d_err,
           mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb
  );

  // Requesters plus memory array side.
  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, d_wstrb, mem_rdata,
    input  i_ack, i_rdata, i_err, d_ack, d_rdata, d_err,
           mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb
  );

endinterface

`default_nettype wire

// File: rtl/mem_port_arbiter_rr2.sv
// ============================================================================
// Module   : mem_arb_rr2
// Purpose  : Combinational two-way round-robin picker (fetch vs. data).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_arb_rr2
  import mem_arb_pkg::*;
(
  input  logic   i_req,
  input  logic   d_req,
  input  grant_t last_grant,
  output grant_t grant,
  output logic   valid
);

  always_comb begin
    grant = GRANT_FETCH;
    valid = i_req | d_req;
    if (i_req && d_req) begin
      grant = (last_grant == GRANT_DATA) ? GRANT_FETCH : GRANT_DATA;
    end else if (d_req) begin
      grant = GRANT_DATA;
    end
  end

endmodule

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
// ============================================================================
// Module   : mem_port_arbiter
// Purpose  : Shares one fixed-latency memory port between fetch and LSU,
//            returning a registered one-cycle ack with data or error.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned MEM_BYTES   = 1024,
  parameter int unsigned MEM_LATENCY = 1
)(
  input  logic       clk,
  input  logic       reset,
  mem_arb_if.slave   bus
);

  localparam logic [2:0] c_S_IDLE  = 3'(IDLE);
  localparam logic [2:0] c_S_ISSUE = 3'(ISSUE);
  localparam logic [2:0] c_S_WAIT  = 3'(WAIT);
  localparam logic [2:0] c_S_RESP  = 3'(RESP);
  localparam logic [2:0] c_S_ERR   = 3'(ERR);

  logic [2:0]  r_state;
  grant_t      r_last_grant;
  grant_t      r_grant;
  logic        r_we;
  logic [2:0]  r_cnt;

  logic        r_i_ack, r_i_err, r_d_ack, r_d_err;
  logic [31:0] r_i_rdata, r_d_rdata;
  logic        r_mem_req, r_mem_we;
  logic [31:0] r_mem_addr, r_mem_wdata;
  logic [3:0]  r_mem_wstrb;

  grant_t      w_grant;
  logic        w_valid;
  logic [31:0] w_addr;
  logic        w_we;
  logic [31:0] w_wdata;
  logic [3:0]  w_wstrb;
  logic        w_addr_ok;

  mem_arb_rr2 u_rr2 (
    .i_req      (bus.i_req),
    .d_req      (bus.d_req),
    .last_grant (r_last_grant),
    .grant      (w_grant),
    .valid      (w_valid)
  );

  always_comb begin
    w_addr  = bus.i_addr;
    w_we    = 1'b0;
    w_wdata = '0;
    w_wstrb = '0;
    if (w_grant == GRANT_DATA) begin
      w_addr  = bus.d_addr;
      w_we    = bus.d_we;
      w_wdata = bus.d_wdata;
      w_wstrb = bus.d_we ? bus.d_wstrb : 4'b0000;
    end
  end

  assign w_addr_ok = addr_ok(w_addr, MEM_BYTES);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= c_S_IDLE;
      r_last_grant <= GRANT_DATA;
      r_grant      <= GRANT_FETCH;
      r_we         <= 1'b0;
      r_cnt        <= '0;
      r_i_ack      <= 1'b0;
      r_i_err      <= 1'b0;
      r_i_rdata    <= '0;
      r_d_ack      <= 1'b0;
      r_d_err      <= 1'b0;
      r_d_rdata    <= '0;
      r_mem_req    <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_mem_wstrb  <= '0;
    end else begin
      // Acks, errors and read data are single-cycle pulses.
      r_i_ack   <= 1'b0;
      r_i_err   <= 1'b0;
      r_i_rdata <= '0;
      r_d_ack   <= 1'b0;
      r_d_err   <= 1'b0;
      r_d_rdata <= '0;
      r_mem_req <= 1'b0;

      case (r_state)
        c_S_IDLE: begin
          if (w_valid) begin
            r_grant <= w_grant;
            r_we    <= w_we;
            if (bus.i_req && bus.d_req) begin
              r_last_grant <= w_grant;
            end
            if (w_addr_ok) begin
              r_mem_req   <= 1'b1;
              r_mem_we    <= w_we;
              r_mem_addr  <= {w_addr[31:2], 2'b00};
              r_mem_wdata <= w_wdata;
              r_mem_wstrb <= w_wstrb;
              r_state     <= c_S_ISSUE;
            end else begin
              if (w_grant == GRANT_FETCH) begin
                r_i_ack <= 1'b1;
                r_i_err <= 1'b1;
              end else begin
                r_d_ack <= 1'b1;
                r_d_err <= 1'b1;
              end
              r_state <= c_S_ERR;
            end
          end
        end

        c_S_ISSUE: begin
          r_cnt       <= 3'(MEM_LATENCY);
          r_mem_we    <= 1'b0;
          r_mem_addr  <= '0;
          r_mem_wdata <= '0;
          r_mem_wstrb <= '0;
          r_state     <= c_S_WAIT;
        end

        c_S_WAIT: begin
          // Counter hitting zero marks the cycle mem_rdata is valid.
          if (r_cnt == 3'd1) begin
            if (r_grant == GRANT_FETCH) begin
              r_i_ack   <= 1'b1;
              r_i_rdata <= bus.mem_rdata;
            end else begin
              r_d_ack   <= 1'b1;
              r_d_rdata <= r_we ? 32'h0 : bus.mem_rdata;
            end
            r_state <= c_S_RESP;
          end
          r_cnt <= r_cnt - 3'd1;
        end

        c_S_RESP, c_S_ERR: r_state <= c_S_IDLE;

        default: r_state <= c_S_IDLE;
      endcase
    end
  end

  assign bus.i_ack     = r_i_ack;
  assign bus.i_rdata   = r_i_rdata;
  assign bus.i_err     = r_i_err;
  assign bus.d_ack     = r_d_ack;
  assign bus.d_rdata   = r_d_rdata;
  assign bus.d_err     = r_d_err;
  assign bus.mem_req   = r_mem_req;
  assign bus.mem_we    = r_mem_we;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;
  assign bus.mem_wstrb = r_mem_wstrb;

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// ============================================================================
// Module   : tb_mem_port_arbiter
// Purpose  : Directed self-checking bench; one arbiter at latency 1 with a
//            writable memory model, one at latency 3 for the reset case.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_port_arbiter;

  logic clk = 1'b0;
  logic rst1 = 1'b1;
  logic rst3 = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  mem_arb_if bus1 ();
  mem_arb_if bus3 ();

  mem_port_arbiter #(.MEM_BYTES(1024), .MEM_LATENCY(1)) u_dut1 (
    .clk(clk), .reset(rst1), .bus(bus1.slave)
  );
  mem_port_arbiter #(.MEM_BYTES(1024), .MEM_LATENCY(3)) u_dut3 (
    .clk(clk), .reset(rst3), .bus(bus3.slave)
  );

  // Latency-1 memory: byte-strobed writes, reads valid one cycle after mem_req.
  logic [31:0] mem1 [256];
  logic [31:0] rd1;
  logic        v1;
  always @(posedge clk) begin
    if (rst1) begin
      for (int i = 0; i < 256; i++) mem1[i] <= 32'h0;
      mem1[2]   <= 32'h00208133;
      mem1[4]   <= 32'h11111111;
      mem1[8]   <= 32'h22222222;
      mem1[255] <= 32'hCAFEF00D;
      v1 <= 1'b0;
      rd1 <= 32'h0;
    end else begin
      v1  <= bus1.mem_req;
      rd1 <= mem1[bus1.mem_addr[9:2]];
      if (bus1.mem_req && bus1.mem_we) begin
        for (int b = 0; b < 4; b++)
          if (bus1.mem_wstrb[b]) mem1[bus1.mem_addr[9:2]][8*b +: 8] <= bus1.mem_wdata[8*b +: 8];
      end
    end
  end
  assign bus1.mem_rdata = v1 ? rd1 : 32'hBAD0BAD0;

  // Latency-3 memory: returns 0x3000_0000 + address, garbage when not valid.
  logic [31:0] p3 [3];
  logic [2:0]  v3;
  always @(posedge clk) begin
    v3    <= {v3[1:0], bus3.mem_req};
    p3[0] <= 32'h30000000 + bus3.mem_addr;
    p3[1] <= p3[0];
    p3[2] <= p3[1];
  end
  assign bus3.mem_rdata = v3[2] ? p3[2] : 32'hBAD0BAD0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus1.i_req = 1'b0; bus1.i_addr = 32'h0;
    bus1.d_req = 1'b0; bus1.d_we = 1'b0; bus1.d_addr = 32'h0;
    bus1.d_wdata = 32'h0; bus1.d_wstrb = 4'h0;
    bus3.i_req = 1'b0; bus3.i_addr = 32'h0;
    bus3.d_req = 1'b0; bus3.d_we = 1'b0; bus3.d_addr = 32'h0;
    bus3.d_wdata = 32'h0; bus3.d_wstrb = 4'h0;
  endtask

  task automatic test_reset();
    logic [139:0] o1, o3;
    tick(); tick();
    o1 = {bus1.i_ack, bus1.i_err, bus1.i_rdata, bus1.d_ack, bus1.d_err, bus1.d_rdata,
          bus1.mem_req, bus1.mem_we, bus1.mem_addr, bus1.mem_wdata, bus1.mem_wstrb};
    o3 = {bus3.i_ack, bus3.i_err, bus3.i_rdata, bus3.d_ack, bus3.d_err, bus3.d_rdata,
          bus3.mem_req, bus3.mem_we, bus3.mem_addr, bus3.mem_wdata, bus3.mem_wstrb};
    n_vec++; if (o1 !== '0) begin n_err++; $display("FAIL reset_outputs_l1 got %h want 0", o1); end
    n_vec++; if (o3 !== '0) begin n_err++; $display("FAIL reset_outputs_l3 got %h want 0", o3); end
    rst1 = 1'b0; rst3 = 1'b0;
    tick();
    n_vec++; if (bus1.mem_req !== 1'b0) begin n_err++; $display("FAIL idle_no_mem_req got %b want 0", bus1.mem_req); end
  endtask

  task automatic test_single_fetch();
    bus1.i_req = 1'b1; bus1.i_addr = 32'h8;
    tick();
    n_vec++; if ({bus1.mem_req, bus1.mem_we, bus1.mem_addr} !== {1'b1, 1'b0, 32'h8})
      begin n_err++; $display("FAIL fetch_issue got req=%b we=%b addr=%h want 1 0 00000008", bus1.mem_req, bus1.mem_we, bus1.mem_addr); end
    tick();
    n_vec++; if ({bus1.mem_req, bus1.i_ack} !== 2'b00)
      begin n_err++; $display("FAIL fetch_wait got req=%b ack=%b want 0 0", bus1.mem_req, bus1.i_ack); end
    tick();
    n_vec++; if ({bus1.i_ack, bus1.i_err, bus1.i_rdata, bus1.d_ack} !== {1'b1, 1'b0, 32'h00208133, 1'b0})
      begin n_err++; $display("FAIL fetch_ack got ack=%b err=%b rdata=%h dack=%b want 1 0 00208133 0", bus1.i_ack, bus1.i_err, bus1.i_rdata, bus1.d_ack); end
    bus1.i_req = 1'b0;
    tick();
    n_vec++; if (bus1.i_ack !== 1'b0) begin n_err++; $display("FAIL fetch_ack_pulse got %b want 0", bus1.i_ack); end
  endtask

  task automatic test_write_read();
    bus1.d_req = 1'b1; bus1.d_we = 1'b1; bus1.d_addr = 32'h4;
    bus1.d_wdata = 32'hDEADBEEF; bus1.d_wstrb = 4'b0011;
    tick();
    n_vec++; if ({bus1.mem_req, bus1.mem_we, bus1.mem_addr, bus1.mem_wdata, bus1.mem_wstrb} !== {1'b1, 1'b1, 32'h4, 32'hDEADBEEF, 4'b0011})
      begin n_err++; $display("FAIL write_issue got req=%b we=%b addr=%h wdata=%h wstrb=%b", bus1.mem_req, bus1.mem_we, bus1.mem_addr, bus1.mem_wdata, bus1.mem_wstrb); end
    tick(); tick();
    n_vec++; if ({bus1.d_ack, bus1.d_err, bus1.d_rdata, bus1.i_ack} !== {1'b1, 1'b0, 32'h0, 1'b0})
      begin n_err++; $display("FAIL write_ack got ack=%b err=%b rdata=%h iack=%b want 1 0 0 0", bus1.d_ack, bus1.d_err, bus1.d_rdata, bus1.i_ack); end
    bus1.d_req = 1'b0;
    tick();
    bus1.d_req = 1'b1; bus1.d_we = 1'b0; bus1.d_wdata = 32'h0; bus1.d_wstrb = 4'b1111;
    tick();
    n_vec++; if ({bus1.mem_req, bus1.mem_we, bus1.mem_wstrb} !== {1'b1, 1'b0, 4'b0000})
      begin n_err++; $display("FAIL read_issue got req=%b we=%b wstrb=%b want 1 0 0000", bus1.mem_req, bus1.mem_we, bus1.mem_wstrb); end
    tick(); tick();
    n_vec++; if ({bus1.d_ack, bus1.d_err, bus1.d_rdata} !== {1'b1, 1'b0, 32'h0000BEEF})
      begin n_err++; $display("FAIL read_ack got ack=%b err=%b rdata=%h want 1 0 0000beef", bus1.d_ack, bus1.d_err, bus1.d_rdata); end
    bus1.d_req = 1'b0;
    tick();
  endtask

  task automatic test_drop_after_grant();
    bus1.i_req = 1'b1; bus1.i_addr = 32'h10;
    tick();
    bus1.i_req = 1'b0; bus1.i_addr = 32'h20;
    tick(); tick();
    n_vec++; if ({bus1.i_ack, bus1.i_rdata} !== {1'b1, 32'h11111111})
      begin n_err++; $display("FAIL drop_after_grant got ack=%b rdata=%h want 1 11111111", bus1.i_ack, bus1.i_rdata); end
    tick();
  endtask

  task automatic test_errors();
    bus1.d_req = 1'b1; bus1.d_we = 1'b0; bus1.d_addr = 32'h6;
    tick();
    n_vec++; if ({bus1.d_ack, bus1.d_err, bus1.d_rdata, bus1.mem_req} !== {1'b1, 1'b1, 32'h0, 1'b0})
      begin n_err++; $display("FAIL misaligned_data got ack=%b err=%b rdata=%h mreq=%b want 1 1 0 0", bus1.d_ack, bus1.d_err, bus1.d_rdata, bus1.mem_req); end
    bus1.d_req = 1'b0;
    tick();
    n_vec++; if ({bus1.d_ack, bus1.mem_req} !== 2'b00)
      begin n_err++; $display("FAIL err_no_access got ack=%b mreq=%b want 0 0", bus1.d_ack, bus1.mem_req); end
    bus1.i_req = 1'b1; bus1.i_addr = 32'h3FE;
    tick();
    n_vec++; if ({bus1.i_ack, bus1.i_err, bus1.i_rdata} !== {1'b1, 1'b1, 32'h0})
      begin n_err++; $display("FAIL fetch_3fe got ack=%b err=%b rdata=%h want 1 1 0", bus1.i_ack, bus1.i_err, bus1.i_rdata); end
    bus1.i_req = 1'b0;
    tick();
    bus1.i_req = 1'b1; bus1.i_addr = 32'h400;
    tick();
    n_vec++; if ({bus1.i_ack, bus1.i_err} !== 2'b11)
      begin n_err++; $display("FAIL fetch_400 got ack=%b err=%b want 1 1", bus1.i_ack, bus1.i_err); end
    bus1.i_req = 1'b0;
    tick();
    bus1.i_req = 1'b1; bus1.i_addr = 32'h3FC;
    tick(); tick(); tick();
    n_vec++; if ({bus1.i_ack, bus1.i_err, bus1.i_rdata} !== {1'b1, 1'b0, 32'hCAFEF00D})
      begin n_err++; $display("FAIL fetch_3fc got ack=%b err=%b rdata=%h want 1 0 cafef00d", bus1.i_ack, bus1.i_err, bus1.i_rdata); end
    bus1.i_req = 1'b0;
    tick();
  endtask

  task automatic test_contention();
    int acks = 0, mreq_cyc = -10, ack_cyc = -10;
    logic outstanding = 1'b0;
    logic exp_f;
    rst1 = 1'b1;
    tick();
    rst1 = 1'b0;
    bus1.i_req = 1'b1; bus1.i_addr = 32'h10;
    bus1.d_req = 1'b1; bus1.d_we = 1'b0; bus1.d_addr = 32'h20;
    for (int cyc = 1; cyc <= 60 && acks < 4; cyc++) begin
      tick();
      if (bus1.mem_req) begin
        n_vec++; if (outstanding !== 1'b0 || (acks > 0 && cyc - ack_cyc != 2) || (acks == 0 && cyc != 1))
          begin n_err++; $display("FAIL contend_issue_gap cyc=%0d last_ack=%0d outstanding=%b want gap 2", cyc, ack_cyc, outstanding); end
        mreq_cyc = cyc; outstanding = 1'b1;
      end
      if (bus1.i_ack || bus1.d_ack) begin
        exp_f = (acks % 2) == 0;
        n_vec++; if ({bus1.i_ack, bus1.d_ack} !== {exp_f, ~exp_f})
          begin n_err++; $display("FAIL contend_order n=%0d got iack=%b dack=%b want %b %b", acks, bus1.i_ack, bus1.d_ack, exp_f, ~exp_f); end
        n_vec++; if (cyc - mreq_cyc != 2)
          begin n_err++; $display("FAIL contend_latency n=%0d got %0d want 2 cycles after mem_req", acks, cyc - mreq_cyc); end
        n_vec++; if ((exp_f ? bus1.i_rdata : bus1.d_rdata) !== (exp_f ? 32'h11111111 : 32'h22222222))
          begin n_err++; $display("FAIL contend_rdata n=%0d got i=%h d=%h", acks, bus1.i_rdata, bus1.d_rdata); end
        outstanding = 1'b0; ack_cyc = cyc; acks++;
        if (acks == 4) begin bus1.i_req = 1'b0; bus1.d_req = 1'b0; end
      end
    end
    n_vec++; if (acks != 4) begin n_err++; $display("FAIL contend_timeout got %0d acks want 4", acks); end
    idle_inputs();
    tick(); tick();
  endtask

  task automatic test_reset_mid_wait();
    logic [139:0] o3;
    int ack_at = -1;
    bus3.i_req = 1'b1; bus3.i_addr = 32'h8;
    tick();
    n_vec++; if (bus3.mem_req !== 1'b1) begin n_err++; $display("FAIL l3_issue got %b want 1", bus3.mem_req); end
    tick();
    rst3 = 1'b1; bus3.i_req = 1'b0;
    tick();
    o3 = {bus3.i_ack, bus3.i_err, bus3.i_rdata, bus3.d_ack, bus3.d_err, bus3.d_rdata,
          bus3.mem_req, bus3.mem_we, bus3.mem_addr, bus3.mem_wdata, bus3.mem_wstrb};
    n_vec++; if (o3 !== '0) begin n_err++; $display("FAIL l3_reset_outputs got %h want 0", o3); end
    n_vec++; if (u_dut3.r_state !== 3'd0) begin n_err++; $display("FAIL l3_reset_state got %0d want 0", u_dut3.r_state); end
    rst3 = 1'b0;
    tick(); tick(); tick();
    n_vec++; if (bus3.i_ack !== 1'b0) begin n_err++; $display("FAIL l3_stale_ack got %b want 0", bus3.i_ack); end
    bus3.i_req = 1'b1; bus3.i_addr = 32'hC;
    for (int cyc = 1; cyc <= 20 && ack_at < 0; cyc++) begin
      tick();
      if (bus3.i_ack) begin
        ack_at = cyc;
        bus3.i_req = 1'b0;
        n_vec++; if ({bus3.i_err, bus3.i_rdata} !== {1'b0, 32'h3000000C})
          begin n_err++; $display("FAIL l3_fresh_rdata got err=%b rdata=%h want 0 3000000c", bus3.i_err, bus3.i_rdata); end
      end
    end
    n_vec++; if (ack_at != 5) begin n_err++; $display("FAIL l3_fresh_latency got %0d want 5", ack_at); end
    bus3.i_req = 1'b0;
    tick();
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_single_fetch();
    test_write_read();
    test_drop_after_grant();
    test_errors();
    test_contention();
    test_reset_mid_wait();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one byte-addressed, word-wide memory port between two requesters: the instruction-fetch unit (read-only) and the load/store unit (read/write, byte strobes).
- Sits between the multicycle core's fetch/LSU logic and the unified memory array.
- Arbitrates round-robin, sequences the fixed-latency memory access, and returns a registered single-cycle ack with read data or an error flag.

Parameters:
- MEM_BYTES, 1024: addressable bytes; an access with addr > MEM_BYTES-4 is out of range.
- MEM_LATENCY, 1: cycles from mem_req high to mem_rdata valid; legal range 1..7.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- i_req  in  1  fetch request; held high with i_addr stable until i_ack.
- i_addr  in  32  fetch byte address.
- i_ack  out  1  one-cycle completion pulse.
- i_rdata  out  32  fetched word; valid when i_ack=1.
- i_err  out  1  misaligned or out-of-range fetch; valid when i_ack=1.
- d_req  in  1  data request; held with its qualifiers until d_ack.
- d_we  in  1  1 = write, 0 = read.
- d_addr  in  32  data byte address.
- d_wdata  in  32  write data.
- d_wstrb  in  4  byte enables for writes; ignored on reads.
- d_ack  out  1  one-cycle completion pulse.
- d_rdata  out  32  read data; valid when d_ack=1 and d_we was 0.
- d_err  out  1  misaligned or out-of-range data access.
- mem_req  out  1  one-cycle memory access strobe.
- mem_we  out  1  write enable qualifying mem_req.
- mem_addr  out  32  word-aligned byte address.
- mem_wdata  out  32  write data.
- mem_wstrb  out  4  byte strobes; 0000 on reads.
- mem_rdata  in  32  read data, valid MEM_LATENCY cycles after mem_req.

Behaviour:
- All outputs are registered.
- Reset values:
  - outputs: all 0.
  - state: IDLE.
  - last_grant: DATA, so fetch wins the first tie.
- States:
  - IDLE: if any request is pending, pick a winner and latch addr/we/wdata/wstrb into registers. Both pending -> grant the requester not equal to last_grant, and update last_grant.
    - Winner's access is erroneous (addr[1:0]!=0, or addr > MEM_BYTES-4) -> ERR.
    - Otherwise -> ISSUE.
  - ISSUE: mem_req=1 for exactly one cycle with the latched fields; load the wait counter with MEM_LATENCY; -> WAIT.
  - WAIT: decrement the counter. The cycle the counter reaches 0 is the rdata-valid cycle: capture mem_rdata; -> RESP.
  - RESP: granted requester's ack=1 and rdata=captured word; err=0; -> IDLE.
  - ERR: granted requester's ack=1 and err=1; rdata=0; no memory access is made; -> IDLE.
- Latency from the request-sampling edge to ack: MEM_LATENCY+2 cycles for a normal access, 1 cycle for an error.
  - Example, MEM_LATENCY=1: req seen in cycle 0, mem_req in cycle 1, mem_rdata in cycle 2, ack in cycle 3.
- Writes follow the same timing. On the ack cycle d_rdata=0.
- i_ack and d_ack are never high in the same cycle. Only one transaction is outstanding at a time.
- A request still high on the ack cycle is not re-sampled until the next IDLE cycle. Back-to-back transactions therefore have at least one idle cycle between ack and the next mem_req.
- A requester dropping req or changing qualifiers after grant has no effect: the latched transaction completes and ack still pulses.
- reset asserted mid-transaction: abort, state=IDLE, all outputs 0, and any in-flight mem_rdata is discarded.
- Sustained contention with both requesting: grants strictly alternate F, D, F, D.

Decomposition:
- Package mem_arb_pkg holds:
  - enum arb_state_t {IDLE, ISSUE, WAIT, RESP, ERR};
  - enum grant_t {GRANT_FETCH, GRANT_DATA};
  - localparam WORD_BYTES=4;
  - function addr_ok(addr, mem_bytes) returning the alignment/range check.
- Sub-module mem_arb_rr2: the combinational 2-way round-robin picker, taking i_req, d_req and last_grant and returning grant and valid.

Test Plan:
- Single fetch, MEM_LATENCY=1: i_req=1, i_addr=0x8, memory holds 0x00208133 -> mem_req pulses in cycle 1 with mem_addr=0x8; i_ack=1 and i_rdata=0x00208133 in cycle 3; d_ack stays 0.
- Data write then read:
  - d_we=1, d_addr=0x4, d_wdata=0xDEADBEEF, d_wstrb=0011 -> mem_wstrb=0011; d_ack with d_err=0 and d_rdata=0.
  - A following read of 0x4 (memory previously 0) -> d_rdata=0x0000BEEF.
- Contention: i_req and d_req both held for 4 transactions -> grant order F, D, F, D; each ack exactly MEM_LATENCY+2 cycles after its grant; no overlapping mem_req.
- Errors:
  - d_addr=0x6 -> d_ack with d_err=1 one cycle after sampling; no mem_req.
  - i_addr=0x3FE (MEM_BYTES=1024) -> i_err=1.
- Reset mid-WAIT (MEM_LATENCY=3): assert reset in WAIT -> next cycle all outputs 0 and state IDLE; a fresh fetch afterwards completes normally.
